// File: rtl/clock_set_controller.sv
// clock_set_controller: button-driven edit sequencer for the time/date counter.
// Detects button presses, walks the three fields of the selected mode, edits a
// shadow copy with per-field wrap-around and strobes a parallel load on commit.
module clock_set_controller #(
    parameter logic [13:0] YEAR_RST = 14'd2024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        butt_increase,
    input  logic        butt_decrease,
    input  logic        butt_change,
    input  logic [5:0]  cur_sec,
    input  logic [5:0]  cur_min,
    input  logic [4:0]  cur_hour,
    input  logic [4:0]  cur_day,
    input  logic [3:0]  cur_month,
    input  logic [13:0] cur_year,
    output logic        run_en,
    output logic        load,
    output logic [5:0]  set_sec,
    output logic [5:0]  set_min,
    output logic [4:0]  set_hour,
    output logic [4:0]  set_day,
    output logic [3:0]  set_month,
    output logic [13:0] set_year,
    output logic [1:0]  edit_field
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F0     = 3'd1,
        ST_F1     = 3'd2,
        ST_F2     = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // Length of a month; February follows the year%4 leap rule.
    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [13:0] year);
        logic [4:0] d;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = (year[1:0] == 2'd0) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // One step up or down inside [lo, hi], wrapping at either end.
    function automatic logic [13:0] wrap_step(input logic [13:0] val,
                                              input logic [13:0] lo,
                                              input logic [13:0] hi,
                                              input logic        up);
        logic [13:0] r;
        if (up) begin
            if (val >= hi) r = lo;
            else           r = val + 14'd1;
        end else begin
            if (val <= lo) r = hi;
            else           r = val - 14'd1;
        end
        return r;
    endfunction

    state_t      state_r;
    logic        edit_mode_r;
    logic        inc_prev_r;
    logic        dec_prev_r;
    logic        chg_prev_r;

    logic        inc_press_s;
    logic        dec_press_s;
    logic        chg_press_s;
    logic        adj_up_s;
    logic        adj_dn_s;
    logic        adj_any_s;
    logic [4:0]  dim_s;
    logic [1:0]  fld_idx_s;
    logic [2:0]  fld_sel_s;
    logic [13:0] fld_val_s;
    logic [13:0] fld_lo_s;
    logic [13:0] fld_hi_s;
    logic [13:0] fld_step_s;

    assign inc_press_s = butt_increase & ~inc_prev_r;
    assign dec_press_s = butt_decrease & ~dec_prev_r;
    assign chg_press_s = butt_change   & ~chg_prev_r;

    // A change press wins over adjustments; opposing adjustments cancel.
    assign adj_up_s  = inc_press_s & ~dec_press_s & ~chg_press_s;
    assign adj_dn_s  = dec_press_s & ~inc_press_s & ~chg_press_s;
    assign adj_any_s = adj_up_s | adj_dn_s;

    assign dim_s = days_in_month(set_month, set_year);

    // Previous button levels for rising-edge press detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_prev_r <= 1'b0;
            dec_prev_r <= 1'b0;
            chg_prev_r <= 1'b0;
        end else begin
            inc_prev_r <= butt_increase;
            dec_prev_r <= butt_decrease;
            chg_prev_r <= butt_change;
        end
    end

    // Select the active field with its legal range and compute its stepped value.
    always_comb begin
        case (state_r)
            ST_F0:   fld_idx_s = 2'd0;
            ST_F1:   fld_idx_s = 2'd1;
            ST_F2:   fld_idx_s = 2'd2;
            default: fld_idx_s = 2'd3;
        endcase
        fld_sel_s = {edit_mode_r, fld_idx_s};
        case (fld_sel_s)
            3'b000: begin fld_val_s = {9'd0, set_hour};  fld_lo_s = 14'd0; fld_hi_s = 14'd23;         end
            3'b001: begin fld_val_s = {8'd0, set_min};   fld_lo_s = 14'd0; fld_hi_s = 14'd59;         end
            3'b010: begin fld_val_s = {8'd0, set_sec};   fld_lo_s = 14'd0; fld_hi_s = 14'd59;         end
            3'b100: begin fld_val_s = {9'd0, set_day};   fld_lo_s = 14'd1; fld_hi_s = {9'd0, dim_s};  end
            3'b101: begin fld_val_s = {10'd0, set_month}; fld_lo_s = 14'd1; fld_hi_s = 14'd12;        end
            3'b110: begin fld_val_s = set_year;          fld_lo_s = 14'd0; fld_hi_s = 14'd9999;       end
            default: begin fld_val_s = 14'd0;            fld_lo_s = 14'd0; fld_hi_s = 14'd0;          end
        endcase
        fld_step_s = wrap_step(fld_val_s, fld_lo_s, fld_hi_s, adj_up_s);
    end

    // Shadow edit registers: capture on entry, adjust the active field, clamp day on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edit_mode_r <= 1'b0;
            set_sec     <= 6'd0;
            set_min     <= 6'd0;
            set_hour    <= 5'd0;
            set_day     <= 5'd1;
            set_month   <= 4'd1;
            set_year    <= YEAR_RST;
        end else if (state_r == ST_IDLE) begin
            if (chg_press_s) begin
                edit_mode_r <= mode;
                set_sec     <= cur_sec;
                set_min     <= cur_min;
                set_hour    <= cur_hour;
                set_day     <= cur_day;
                set_month   <= cur_month;
                set_year    <= cur_year;
            end
        end else if ((state_r == ST_F2) && chg_press_s) begin
            if (edit_mode_r && (set_day > dim_s)) begin
                set_day <= dim_s;
            end
        end else if (adj_any_s) begin
            case (fld_sel_s)
                3'b000:  set_hour  <= fld_step_s[4:0];
                3'b001:  set_min   <= fld_step_s[5:0];
                3'b010:  set_sec   <= fld_step_s[5:0];
                3'b100:  set_day   <= fld_step_s[4:0];
                3'b101:  set_month <= fld_step_s[3:0];
                3'b110:  set_year  <= fld_step_s;
                default: ;
            endcase
        end
    end

    // Edit sequencer with registered run/load/field-indicator outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            run_en     <= 1'b1;
            load       <= 1'b0;
            edit_field <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (chg_press_s) begin
                        state_r    <= ST_F0;
                        run_en     <= 1'b0;
                        edit_field <= 2'd1;
                    end
                end
                ST_F0: begin
                    if (chg_press_s) begin
                        state_r    <= ST_F1;
                        edit_field <= 2'd2;
                    end
                end
                ST_F1: begin
                    if (chg_press_s) begin
                        state_r    <= ST_F2;
                        edit_field <= 2'd3;
                    end
                end
                ST_F2: begin
                    if (chg_press_s) begin
                        state_r    <= ST_COMMIT;
                        edit_field <= 2'd0;
                        load       <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                    run_en  <= 1'b1;
                    load    <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    run_en     <= 1'b1;
                    load       <= 1'b0;
                    edit_field <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Testbench for clock_set_controller: directed scenarios followed by random
// button/mode/counter stimulus, all checked against a field-level reference model.
module tb_clock_set_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        butt_increase = 1'b0;
    logic        butt_decrease = 1'b0;
    logic        butt_change = 1'b0;
    logic [5:0]  cur_sec = 6'd0;
    logic [5:0]  cur_min = 6'd0;
    logic [4:0]  cur_hour = 5'd0;
    logic [4:0]  cur_day = 5'd1;
    logic [3:0]  cur_month = 4'd1;
    logic [13:0] cur_year = 14'd0;
    logic        run_en;
    logic        load;
    logic [5:0]  set_sec;
    logic [5:0]  set_min;
    logic [4:0]  set_hour;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [13:0] set_year;
    logic [1:0]  edit_field;

    clock_set_controller #(.YEAR_RST(14'd2024)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .butt_increase(butt_increase), .butt_decrease(butt_decrease), .butt_change(butt_change),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .run_en(run_en), .load(load),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = idle, 1..3 = editing field 1..3, 4 = commit.
    int m_phase;
    bit m_date;
    int m_hour, m_min, m_sec, m_day, m_month, m_year;
    bit p_inc, p_dec, p_chg;

    function automatic int month_len(int mo, int y);
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        else if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        else return 31;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_date = 1'b0;
        m_hour = 0; m_min = 0; m_sec = 0;
        m_day = 1; m_month = 1; m_year = 2024;
        p_inc = 1'b0; p_dec = 1'b0; p_chg = 1'b0;
    endtask

    task automatic model_adjust(input int delta);
        int which;
        which = (m_date ? 3 : 0) + m_phase - 1;
        case (which)
            0: m_hour  = (m_hour + 24 + delta) % 24;
            1: m_min   = (m_min + 60 + delta) % 60;
            2: m_sec   = (m_sec + 60 + delta) % 60;
            3: m_day   = (m_day - 1 + delta + month_len(m_month, m_year)) % month_len(m_month, m_year) + 1;
            4: m_month = (m_month - 1 + delta + 12) % 12 + 1;
            default: m_year = (m_year + delta + 10000) % 10000;
        endcase
    endtask

    task automatic model_edge(input bit i, input bit d, input bit c);
        bit ip, dp, cp;
        ip = i && !p_inc; dp = d && !p_dec; cp = c && !p_chg;
        p_inc = i; p_dec = d; p_chg = c;
        if (m_phase == 0) begin
            if (cp) begin
                m_hour = int'(cur_hour); m_min = int'(cur_min); m_sec = int'(cur_sec);
                m_day = int'(cur_day); m_month = int'(cur_month); m_year = int'(cur_year);
                m_date = mode;
                m_phase = 1;
            end
        end else if (m_phase <= 3) begin
            if (cp) begin
                if (m_phase == 3 && m_date && m_day > month_len(m_month, m_year))
                    m_day = month_len(m_month, m_year);
                m_phase++;
            end else if (ip != dp) begin
                model_adjust(ip ? 1 : -1);
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all();
        check("run_en",     32'(run_en),     (m_phase == 0) ? 1 : 0);
        check("load",       32'(load),       (m_phase == 4) ? 1 : 0);
        check("edit_field", 32'(edit_field), (m_phase >= 1 && m_phase <= 3) ? m_phase : 0);
        check("set_hour",   32'(set_hour),   m_hour);
        check("set_min",    32'(set_min),    m_min);
        check("set_sec",    32'(set_sec),    m_sec);
        check("set_day",    32'(set_day),    m_day);
        check("set_month",  32'(set_month),  m_month);
        check("set_year",   32'(set_year),   m_year);
    endtask

    task automatic cycle(input bit i, input bit d, input bit c);
        butt_increase = i; butt_decrease = d; butt_change = c;
        @(posedge clk);
        model_edge(i, d, c);
        #1;
        check_all();
    endtask

    task automatic press(input bit i, input bit d, input bit c);
        cycle(i, d, c);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_cur(input int h, input int mi, input int s, input int d, input int mo, input int y);
        cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
        cur_day = 5'(d); cur_month = 4'(mo); cur_year = 14'(y);
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_run_en"},     32'(run_en),     32'd1);
        check({tag, "_load"},       32'(load),       32'd0);
        check({tag, "_edit_field"}, 32'(edit_field), 32'd0);
        check({tag, "_day"},        32'(set_day),    32'd1);
        check({tag, "_month"},      32'(set_month),  32'd1);
        check({tag, "_year"},       32'(set_year),   32'd2024);
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r_y, r_mo;
        model_reset();

        // Reset asserted between clock edges.
        #3;
        async_reset_check("rst0");

        // Time edit from 23:59:58.
        set_cur(23, 59, 58, 15, 6, 2020);
        mode = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        check("time_hour_wrap", 32'(set_hour), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        check("time_min_dec", 32'(set_min), 32'd58);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("time_sec_wrap", 32'(set_sec), 32'd0);
        cycle(1'b0, 1'b0, 1'b1);
        check("time_load", 32'(load), 32'd1);
        check("time_load_hms", {set_hour, set_min, set_sec}, {5'd0, 6'd58, 6'd0});
        cycle(1'b0, 1'b0, 1'b0);
        check("time_idle_after", 32'(run_en), 32'd1);

        // Date clamp: 31/01/2024 -> Feb 2025 gives 28, Feb 2024 gives 29.
        for (int k = 0; k < 2; k++) begin
            set_cur(12, 0, 0, 31, 1, 2024);
            mode = 1'b1;
            press(1'b0, 1'b0, 1'b1);
            press(1'b0, 1'b0, 1'b1);
            press(1'b1, 1'b0, 1'b0);
            check("date_month", 32'(set_month), 32'd2);
            press(1'b0, 1'b0, 1'b1);
            if (k == 0) press(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            check("date_clamp_load", 32'(load), 32'd1);
            check("date_clamp_day", 32'(set_day), (k == 0) ? 32'd28 : 32'd29);
            cycle(1'b0, 1'b0, 1'b0);
        end

        // Wraps: day 30 in April, year 9999 up and back down.
        set_cur(1, 2, 3, 30, 4, 9999);
        mode = 1'b1;
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        check("wrap_day", 32'(set_day), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        check("wrap_year_up", 32'(set_year), 32'd0);
        press(1'b0, 1'b1, 1'b0);
        check("wrap_year_dn", 32'(set_year), 32'd9999);
        press(1'b0, 1'b0, 1'b1);

        // Held button, simultaneous presses, mode change mid-edit.
        set_cur(10, 20, 30, 5, 5, 2001);
        mode = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("hold_once", 32'(set_hour), 32'd11);
        press(1'b1, 1'b1, 1'b0);
        check("inc_dec_same", 32'(set_hour), 32'd11);
        press(1'b1, 1'b0, 1'b1);
        check("chg_inc_field", 32'(edit_field), 32'd2);
        check("chg_inc_hour", 32'(set_hour), 32'd11);
        mode = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        check("mode_latch_min", 32'(set_min), 32'd21);
        check("mode_latch_month", 32'(set_month), 32'd5);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);

        // Presses while idle do nothing.
        repeat (3) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("idle_hour", 32'(set_hour), 32'd11);

        // Reset in the middle of an edit.
        mode = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        check("pre_rst_field", 32'(edit_field), 32'd2);
        #2;
        async_reset_check("rst_f1");
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Random buttons, mode and live counter values.
        repeat (600) begin
            r_y  = int'($urandom_range(0, 9999));
            r_mo = int'($urandom_range(1, 12));
            set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                    int'($urandom_range(0, 59)),
                    int'($urandom_range(1, 32'(month_len(r_mo, r_y)))), r_mo, r_y);
            mode = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

User-edit sequencer for the decade clock's time/date counter. Detects presses on the increase, decrease and change buttons, and steps through the fields of the selected display mode. It edits a shadow copy of the fields with per-field wrap-around. It freezes the counter while editing and issues a one-cycle parallel-load strobe on commit. It sits between the debounced button inputs and the time/date counter's load port.

## Interface
- `YEAR_RST`, default 2024: reset value of `set_year`.
- `clk`  in  1: system clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mode`  in  1: 0 = time (hour/min/sec), 1 = date (day/month/year); sampled only on edit entry.
- `butt_increase`, `butt_decrease`, `butt_change`  in  1 each: synchronized, debounced, active-high levels.
- `cur_sec` in 6, `cur_min` in 6, `cur_hour` in 5, `cur_day` in 5, `cur_month` in 4, `cur_year` in 14: live counter values.
- `run_en`  out  1: 1 = counter may advance; 0 while editing or committing.
- `load`  out  1: one-cycle strobe; counter loads all `set_*` fields on the edge ending it.
- `set_sec` out 6, `set_min` out 6, `set_hour` out 5, `set_day` out 5, `set_month` out 4, `set_year` out 14: registered edit values, always driven.
- `edit_field`  out  2: 0 = none, 1 = field0 (hour/day), 2 = field1 (min/month), 3 = field2 (sec/year); used by the display for blanking/blink.

## Operation
- **Press detection:** one registered previous level per button. A press is `level & ~prev`. A held button yields exactly one press.
- **FSM states:** IDLE, F0, F1, F2, COMMIT.
  - IDLE: on a change press, copy all `cur_*` into the edit registers, latch `mode` into `edit_mode`, and go to F0.
  - F0 → F1 → F2 on a change press.
  - F2 → COMMIT on a change press. If `edit_mode`=1, `set_day` is clamped to the days-in-month of (`set_month`, `set_year`) on that same edge.
  - COMMIT → IDLE unconditionally after 1 cycle.
- **Field selection:** `edit_mode`=0 selects hour/min/sec for F0/F1/F2. `edit_mode`=1 selects day/month/year.
- **Increase/decrease ranges:** in F0–F2, an increase or decrease press adjusts only the active field, with wrap-around:
  - hour 0..23; min and sec 0..59.
  - month 1..12; year 0..9999.
  - day 1..D, where D = 31 for months 1/3/5/7/8/10/12, 30 for 4/6/9/11, and for month 2: 29 if `set_year`%4==0, else 28.
  - Example: 23+1→0; 0−1→23; 59+1→0; day 1−1→D; year 9999+1→0; year 0−1→9999.
- **Simultaneous events:**
  - increase and decrease presses in the same cycle: no change.
  - change press with increase/decrease in the same cycle: the change is taken and the adjustment is dropped.
  - increase/decrease in IDLE or COMMIT: ignored.
- **Mode:** changes of `mode` during F0–COMMIT are ignored.
- **Outputs:**
  - `run_en` = (state==IDLE).
  - `load` = (state==COMMIT).
  - `edit_field` = 1/2/3 in F0/F1/F2, and 0 otherwise.
  - Non-edited `set_*` fields hold the values captured at entry, so commit reloads them unchanged. Live seconds elapsed during editing are discarded.
- **Reset:**
  - state = IDLE, `run_en`=1, `load`=0, `edit_field`=0, `edit_mode`=0, all prev levels = 0.
  - `set_sec`=0, `set_min`=0, `set_hour`=0, `set_day`=1, `set_month`=1, `set_year`=`YEAR_RST`.
  - Reset mid-edit abandons the edit with no `load` pulse.

## Timing
- A button high at rising edge N (low at N−1) acts at edge N. Its effect is visible after N.
- **Entry:** change press at edge N. From N: state=F0, `run_en`=0, `edit_field`=1, `set_*` = `cur_*` as sampled at N.
- **Adjust latency:** 1 cycle from press sample to new `set_*` value.
- **Commit:**
  - change press in F2 at edge N → `load`=1 for the cycle N..N+1, with `set_*` stable.
  - The counter loads at edge N+1.
  - From N+1: IDLE, `run_en`=1, `load`=0.
- Minimum full edit: 4 change presses. `run_en` is low from the first press edge through the edge after the fourth.
- All outputs are registered or decoded from state only; there is no combinational path from button inputs to outputs.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → immediately `run_en`=1, `load`=0, `edit_field`=0, `set_day`=1, `set_month`=1, `set_year`=2024. Repeat with `rst` asserted while in F1 → return to IDLE with no `load`.
- **Time edit:** `cur`=23:59:58, `mode`=0.
  - Press change, then increase on hour → `set_hour`=0.
  - Change, then decrease on min → `set_min`=58.
  - Change, then increase ×2 on sec → `set_sec`=0.
  - Final change → one `load` pulse carrying 00:58:00; `edit_field` sequence 1, 2, 3, 0.
- **Date clamp, leap year:** `cur` = 31/01/2024, `mode`=1.
  - Change ×2, then increase on month → month 2.
  - Change, then increase on year → 2025.
  - Change → `set_day`=28 during `load`.
  - Repeat with year left at 2024 → `set_day`=29.
- **Wraps:** in F0, date mode, month=4, day=30, increase → day 1. Year 9999 increase → 0; year 0 decrease → 9999.
- **Hold and simultaneous presses:**
  - `butt_increase` held 10 cycles → exactly +1.
  - increase and decrease rising on the same edge → value unchanged.
  - change and increase on the same edge in F0 → advance to F1 with hour unchanged.
- **Mode latch and idle presses:**
  - toggle `mode` during F1 → fields still time fields.
  - increase presses in IDLE → `set_*` unchanged and `load` stays 0.
